// File: rtl/mips_isa_pkg.sv
// MIPS32 instruction-format definitions shared by the field decoder and encoder:
// format codes, field widths/positions and the opcodes the loaders care about.
package mips_isa_pkg;

    typedef enum logic [1:0] {
        FMT_R    = 2'd0,
        FMT_I    = 2'd1,
        FMT_J    = 2'd2,
        FMT_RSVD = 2'd3
    } fmt_e;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    localparam logic [OPCODE_W-1:0] OP_SPECIAL = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J       = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_ADDI    = 6'h08;

    // R-type lives entirely under the SPECIAL opcode; I/J must not use it.
    function automatic logic is_legal(input fmt_e fmt, input logic [OPCODE_W-1:0] opcode);
        case (fmt)
            FMT_R:   is_legal = (opcode == OP_SPECIAL);
            FMT_I:   is_legal = (opcode != OP_SPECIAL);
            FMT_J:   is_legal = (opcode != OP_SPECIAL);
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_packer_32.sv
// Combinational packing of instruction fields into a 32-bit MIPS word,
// plus a flag telling whether the field bundle forms a legal instruction.
module instruction_packer_32
    import mips_isa_pkg::*;
(
    input  logic [1:0]          format,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [FUNCT_W-1:0]  alu_function,
    input  logic [IMM_W-1:0]    immediate,
    input  logic [TARGET_W-1:0] jump_target,
    output logic [31:0]         word,
    output logic                legal
);

    fmt_e fmt;

    assign fmt = fmt_e'(format);

    always_comb begin
        word  = '0;
        legal = is_legal(fmt, opcode);
        case (fmt)
            FMT_R: begin
                word[OPCODE_MSB:OPCODE_LSB] = opcode;
                word[RS_MSB:RS_LSB]         = rs;
                word[RT_MSB:RT_LSB]         = rt;
                word[RD_MSB:RD_LSB]         = rd;
                word[SHAMT_MSB:SHAMT_LSB]   = shamt;
                word[FUNCT_MSB:FUNCT_LSB]   = alu_function;
            end
            FMT_I: begin
                word[OPCODE_MSB:OPCODE_LSB] = opcode;
                word[RS_MSB:RS_LSB]         = rs;
                word[RT_MSB:RT_LSB]         = rt;
                word[IMM_MSB:IMM_LSB]       = immediate;
            end
            FMT_J: begin
                word[OPCODE_MSB:OPCODE_LSB] = opcode;
                word[TARGET_MSB:TARGET_LSB] = jump_target;
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instruction_encoder_32.sv
// Accepts instruction field bundles over valid/ready, packs them and streams the
// words into instruction memory at an auto-incrementing word address.
module instruction_encoder_32
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int RESET_ADDR = 0
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_format,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [REG_W-1:0]    in_rs,
    input  logic [REG_W-1:0]    in_rt,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [SHAMT_W-1:0]  in_shamt,
    input  logic [FUNCT_W-1:0]  in_alu_function,
    input  logic [IMM_W-1:0]    in_immediate,
    input  logic [TARGET_W-1:0] in_jump_target,
    input  logic                load_address,
    input  logic [ADDR_W-1:0]   start_address,
    output logic                imem_write_enable,
    input  logic                imem_ready,
    output logic [ADDR_W-1:0]   imem_address,
    output logic [31:0]         imem_write_data,
    output logic [ADDR_W:0]     word_count,
    output logic                wrapped,
    output logic                error,
    input  logic                error_clear
);

    localparam logic [ADDR_W-1:0] RESET_VAL = RESET_ADDR[ADDR_W-1:0];

    logic [31:0] packed_word;
    logic        bundle_legal;
    logic        accept;
    logic        complete;
    logic        wrap_now;

    instruction_packer_32 u_packer (
        .format       (in_format),
        .opcode       (in_opcode),
        .rs           (in_rs),
        .rt           (in_rt),
        .rd           (in_rd),
        .shamt        (in_shamt),
        .alu_function (in_alu_function),
        .immediate    (in_immediate),
        .jump_target  (in_jump_target),
        .word         (packed_word),
        .legal        (bundle_legal)
    );

    assign in_ready = !imem_write_enable || imem_ready;
    assign accept   = in_valid && in_ready;
    assign complete = imem_write_enable && imem_ready;
    // A reload in the same cycle replaces the increment, so it cannot wrap.
    assign wrap_now = complete && !load_address && (&imem_address);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_write_enable <= 1'b0;
            imem_write_data   <= '0;
        end else if (accept) begin
            imem_write_enable <= bundle_legal;
            if (bundle_legal) begin
                imem_write_data <= packed_word;
            end
        end else if (complete) begin
            imem_write_enable <= 1'b0;
        end
    end

    // The pending write always targets the live counter, so a reload retargets it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_address <= RESET_VAL;
            word_count   <= '0;
        end else if (load_address) begin
            imem_address <= start_address;
            word_count   <= '0;
        end else if (complete) begin
            imem_address <= imem_address + 1'b1;
            if (!(&word_count)) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrapped <= 1'b0;
            error   <= 1'b0;
        end else begin
            if (error_clear) begin
                wrapped <= 1'b0;
                error   <= 1'b0;
            end
            if (wrap_now) begin
                wrapped <= 1'b1;
            end
            if (accept && !bundle_legal) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder_32.sv
// Randomized plus directed bench for instruction_encoder_32 against a
// transaction-level model of the loader (one outstanding word, counters, sticky flags).
module tb_instruction_encoder_32;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CMAX   = (2 * DEPTH) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_format;
    logic [5:0]        in_opcode;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_alu_function;
    logic [15:0]       in_immediate;
    logic [25:0]       in_jump_target;
    logic              load_address;
    logic [ADDR_W-1:0] start_address;
    logic              imem_write_enable;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_write_data;
    logic [ADDR_W:0]   word_count;
    logic              wrapped;
    logic              error;
    logic              error_clear;

    int vectors     = 0;
    int miscompares = 0;

    bit          mPending;
    logic [31:0] mData;
    int unsigned mAddr;
    int unsigned mCount;
    bit          mWrapped;
    bit          mError;

    logic [31:0] heldData;
    logic [31:0] heldAddr;

    instruction_encoder_32 #(.ADDR_W(ADDR_W), .RESET_ADDR(0)) dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_format         (in_format),
        .in_opcode         (in_opcode),
        .in_rs             (in_rs),
        .in_rt             (in_rt),
        .in_rd             (in_rd),
        .in_shamt          (in_shamt),
        .in_alu_function   (in_alu_function),
        .in_immediate      (in_immediate),
        .in_jump_target    (in_jump_target),
        .load_address      (load_address),
        .start_address     (start_address),
        .imem_write_enable (imem_write_enable),
        .imem_ready        (imem_ready),
        .imem_address      (imem_address),
        .imem_write_data   (imem_write_data),
        .word_count        (word_count),
        .wrapped           (wrapped),
        .error             (error),
        .error_clear       (error_clear)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Instruction word built directly from the MIPS field layout by arithmetic.
    function automatic logic [31:0] expectWord(input int f, input int unsigned op, input int unsigned rs,
                                                input int unsigned rt, input int unsigned rd, input int unsigned sh,
                                                input int unsigned fn, input int unsigned imm, input int unsigned tgt);
        int unsigned w;
        case (f)
            0:       w = op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * 64 + fn;
            1:       w = op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
            default: w = op * (1 << 26) + tgt;
        endcase
        return w;
    endfunction

    function automatic bit expectLegal(input int f, input int unsigned op);
        return (f == 0 && op == 0) || ((f == 1 || f == 2) && op != 0);
    endfunction

    task automatic modelReset();
        mPending = 0;
        mData    = '0;
        mAddr    = 0;
        mCount   = 0;
        mWrapped = 0;
        mError   = 0;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] f, input logic [5:0] op,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                                 input logic [25:0] tgt, input logic rdy, input logic ld,
                                 input logic [ADDR_W-1:0] sa, input logic clr);
        in_valid        = v;
        in_format       = f;
        in_opcode       = op;
        in_rs           = rs;
        in_rt           = rt;
        in_rd           = rd;
        in_shamt        = sh;
        in_alu_function = fn;
        in_immediate    = imm;
        in_jump_target  = tgt;
        imem_ready      = rdy;
        load_address    = ld;
        start_address   = sa;
        error_clear     = clr;
    endtask

    task automatic applyIdle(input logic rdy);
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, rdy, 1'b0, '0, 1'b0);
    endtask

    task automatic applyRandom();
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] r3;
        logic [5:0]  op;
        r1 = $urandom;
        r2 = $urandom;
        r3 = $urandom;
        op = ($urandom_range(0, 2) == 0) ? 6'd0 : r1[31:26];
        applyStimulus($urandom_range(0, 3) != 0, r1[1:0], op, r1[6:2], r1[11:7], r1[16:12],
                      r1[21:17], r2[5:0], r2[21:6], r3[25:0], $urandom_range(0, 3) != 0,
                      $urandom_range(0, 63) == 0, r3[29:26], $urandom_range(0, 31) == 0);
    endtask

    task automatic settle();
        #1;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !mPending || imem_ready});
        checkOutput("write_enable", {31'd0, imem_write_enable}, {31'd0, mPending});
        checkOutput("address", {28'd0, imem_address}, mAddr);
        checkOutput("word_count", {27'd0, word_count}, mCount);
        checkOutput("wrapped", {31'd0, wrapped}, {31'd0, mWrapped});
        checkOutput("error", {31'd0, error}, {31'd0, mError});
        if (mPending) begin
            checkOutput("write_data", imem_write_data, mData);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven, then wait.
    task automatic advance();
        bit acc;
        bit cmp;
        acc = in_valid && (!mPending || imem_ready);
        cmp = mPending && imem_ready;
        if (error_clear) begin
            mError   = 0;
            mWrapped = 0;
        end
        if (cmp) begin
            if (!load_address) begin
                if (mAddr == DEPTH - 1) mWrapped = 1;
                mAddr = (mAddr + 1) % DEPTH;
            end
            if (mCount < CMAX) mCount++;
        end
        if (load_address) begin
            mAddr  = start_address;
            mCount = 0;
        end
        if (acc) begin
            if (expectLegal(in_format, in_opcode)) begin
                mPending = 1;
                mData    = expectWord(in_format, in_opcode, in_rs, in_rt, in_rd, in_shamt,
                                      in_alu_function, in_immediate, in_jump_target);
            end else begin
                mPending = 0;
                mError   = 1;
            end
        end else if (cmp) begin
            mPending = 0;
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        applyIdle(1'b1);
        modelReset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        applyIdle(1'b1);
        settle();
        advance();

        // add $3,$1,$2
        applyStimulus(1, 2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1, 0, '0, 0);
        settle();
        advance();

        // addi issued together with a reload to 0, then a jump straight behind it
        applyStimulus(1, 2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'd5, 26'd0, 1, 1, '0, 0);
        settle();
        checkOutput("add_data", imem_write_data, 32'h00221820);
        checkOutput("add_addr", {28'd0, imem_address}, 32'd0);
        advance();
        applyStimulus(1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h0100000, 1, 0, '0, 0);
        settle();
        checkOutput("addi_data", imem_write_data, 32'h20080005);
        checkOutput("addi_addr", {28'd0, imem_address}, 32'd0);
        advance();
        applyIdle(1'b1);
        settle();
        checkOutput("j_data", imem_write_data, 32'h08100000);
        checkOutput("j_addr", {28'd0, imem_address}, 32'd1);
        advance();
        applyIdle(1'b1);
        settle();
        checkOutput("b2b_count", {27'd0, word_count}, 32'd2);
        advance();

        // back-pressure: a write held pending across three stalled cycles
        applyStimulus(1, 2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd7, 6'h22, 16'd0, 26'd0, 1, 0, '0, 0);
        settle();
        advance();
        heldData = imem_write_data;
        heldAddr = {28'd0, imem_address};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 2'd1, 6'h0d, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'hbeef, 26'd0, 0, 0, '0, 0);
            settle();
            checkOutput("stall_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall_data", imem_write_data, heldData);
            checkOutput("stall_addr", {28'd0, imem_address}, heldAddr);
            advance();
        end
        applyStimulus(1, 2'd1, 6'h0d, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'hbeef, 26'd0, 1, 0, '0, 0);
        settle();
        advance();
        applyIdle(1'b1);
        settle();
        checkOutput("stall_next_addr", {28'd0, imem_address}, heldAddr + 1);
        advance();

        // illegal bundles are swallowed and flagged
        applyIdle(1'b1);
        settle();
        heldAddr = {28'd0, imem_address};
        advance();
        applyStimulus(1, 2'd0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1, 0, '0, 0);
        settle();
        advance();
        applyStimulus(1, 2'd3, 6'h10, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1, 0, '0, 0);
        settle();
        checkOutput("illegal_error", {31'd0, error}, 32'd1);
        advance();
        applyStimulus(0, 2'd0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'd0, 1, 0, '0, 1);
        settle();
        checkOutput("illegal_we", {31'd0, imem_write_enable}, 32'd0);
        checkOutput("illegal_addr", {28'd0, imem_address}, heldAddr);
        advance();
        applyIdle(1'b1);
        settle();
        checkOutput("cleared_error", {31'd0, error}, 32'd0);
        advance();

        // reload near the top of the address space and wrap
        applyStimulus(0, 2'd0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'd0, 1, 1, 4'd15, 0);
        settle();
        advance();
        applyStimulus(1, 2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h0000040, 1, 0, '0, 0);
        settle();
        advance();
        applyStimulus(1, 2'd1, 6'h23, 5'd29, 5'd9, 5'd0, 5'd0, 6'h00, 16'hfffc, 26'd0, 1, 0, '0, 0);
        settle();
        checkOutput("wrap_first_addr", {28'd0, imem_address}, 32'd15);
        advance();
        applyIdle(1'b1);
        settle();
        checkOutput("wrap_second_addr", {28'd0, imem_address}, 32'd0);
        checkOutput("wrap_flag", {31'd0, wrapped}, 32'd1);
        advance();

        // reset while a write is stalled
        applyStimulus(1, 2'd0, 6'h00, 5'd7, 5'd7, 5'd7, 5'd1, 6'h00, 16'd0, 26'd0, 0, 0, '0, 0);
        settle();
        advance();
        applyStimulus(0, 2'd0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'd0, 0, 0, '0, 0);
        settle();
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_we", {31'd0, imem_write_enable}, 32'd0);
        checkOutput("rst_addr", {28'd0, imem_address}, 32'd0);
        checkOutput("rst_count", {27'd0, word_count}, 32'd0);
        checkOutput("rst_wrapped", {31'd0, wrapped}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        modelReset();
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            applyRandom();
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
